// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: turns one decoded load/store into a single-beat
// data-bus transaction with lane steering, alignment check, load extension and timeout.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        func3_q;
    logic [31:0]       rdata_q;

    logic              req_any, req_both, illegal, unaligned;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic              latch_en, load_en;

    // Extract and extend the addressed lane of a read word
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = d >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'd0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = d;
        endcase
    endfunction

    // Request decode, legality/alignment checks and store lane steering
    always_comb begin
        req_any  = mem_read_i | mem_write_i;
        req_both = mem_read_i & mem_write_i;
        if (mem_write_i) begin
            illegal = func3_i[2] | (func3_i[1:0] == 2'b11);
        end else begin
            illegal = (func3_i[1:0] == 2'b11) | (func3_i[2] & func3_i[1]);
        end
        case (func3_i[1:0])
            2'b01:   unaligned = addr_i[0];
            2'b10:   unaligned = (addr_i[1:0] != 2'b00);
            default: unaligned = 1'b0;
        endcase
        case (func3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_i[1:0];
                wdata_c = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata_i[15:0]}};
            end
            default: begin
                be_c    = 4'hF;
                wdata_c = wdata_i;
            end
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        bus_req_o  = 1'b0;
        latch_en   = 1'b0;
        load_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_both) begin
                    done_o    = 1'b1;
                    bus_err_o = 1'b1;
                end else if (req_any && (illegal || unaligned)) begin
                    done_o     = 1'b1;
                    misalign_o = 1'b1;
                end else if (req_any) begin
                    stall_o  = 1'b1;
                    latch_en = 1'b1;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                stall_o   = 1'b1;
                bus_req_o = 1'b1;
                if (bus_gnt_i) begin
                    if (we_q) begin
                        err_d   = bus_err_i;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                stall_o = 1'b1;
                if (bus_rvalid_i) begin
                    err_d   = bus_err_i;
                    load_en = ~bus_err_i;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_o    = 1'b1;
                bus_err_o = err_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, timeout counter and transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (latch_en) begin
                addr_q  <= addr_i;
                we_q    <= mem_write_i;
                be_q    <= be_c;
                wdata_q <= wdata_c;
                func3_q <= func3_i;
            end
            if (load_en) begin
                rdata_q <= fmt_load(func3_q, addr_q[1:0], bus_rdata_i);
            end
        end
    end

    assign rdata_o     = rdata_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: transaction-level reference model with per-cycle compare.
module tb_lsu_mem_port;

    localparam int unsigned TIMEOUT = 64;

    logic        clk, rst_n;
    logic        mem_read, mem_write, gnt, rvalid, berr_in;
    logic [2:0]  func3;
    logic [31:0] addr, wdata, brdata;
    logic [31:0] rdata, baddr, bwdata;
    logic [3:0]  bbe;
    logic        stall, done, misalign, berr, breq, bwe;

    lsu_mem_port #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .func3_i(func3),
        .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .stall_o(stall), .done_o(done),
        .misalign_o(misalign), .bus_err_o(berr),
        .bus_req_o(breq), .bus_we_o(bwe), .bus_addr_o(baddr),
        .bus_be_o(bbe), .bus_wdata_o(bwdata),
        .bus_gnt_i(gnt), .bus_rvalid_i(rvalid), .bus_rdata_i(brdata), .bus_err_i(berr_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic        chk_en;
    logic        e_stall, e_done, e_mis, e_berr, e_req, e_we;
    logic [31:0] e_addr, e_wdata, model_rdata;
    logic [3:0]  e_be;
    int          lat_run, last_lat, req_cnt;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Byte enables: a naturally aligned window of 2**size bytes
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n, off;
        n   = 1 << int'(f3[1:0]);
        off = int'(a[1:0]) & ~(n - 1);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] b, h;
        b = 32'(w[7:0]);
        h = 32'(w[15:0]);
        if (f3[1:0] == 2'b00) return b * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return h * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
        int    bits;
        longint val;
        bits = 8 << int'(f3[1:0]);
        if (bits >= 32) return d;
        val = longint'(d >> (8 * int'(a[1:0]))) & ((64'd1 << bits) - 1);
        if (!f3[2] && val >= longint'(64'd1 << (bits - 1))) val = val - longint'(64'd1 << bits);
        return 32'(val);
    endfunction

    // {bus_err, misalign} that the request must produce in IDLE
    function automatic logic [1:0] m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                           input logic [31:0] a);
        int unsigned sz;
        logic ill;
        if (rd && wr) return 2'b10;
        sz  = int'(f3[1:0]);
        ill = (sz == 3) || (f3[2] && (wr || sz == 2));
        if (ill) return 2'b01;
        if ((a % (32'd1 << sz)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic cycle_check();
        if (chk_en) begin
            cmp("stall", 32'(stall), 32'(e_stall));
            cmp("done", 32'(done), 32'(e_done));
            cmp("misalign", 32'(misalign), 32'(e_mis));
            cmp("bus_err", 32'(berr), 32'(e_berr));
            cmp("bus_req", 32'(breq), 32'(e_req));
            cmp("rdata", rdata, model_rdata);
            if (e_req) begin
                cmp("bus_we", 32'(bwe), 32'(e_we));
                cmp("bus_addr", baddr, e_addr);
                cmp("bus_be", 32'(bbe), 32'(e_be));
                if (e_we) cmp("bus_wdata", bwdata, e_wdata);
            end
        end
        if (!rst_n) begin
            lat_run = 0;
        end else begin
            if (stall || done) lat_run++;
            if (done) begin
                last_lat = lat_run;
                lat_run  = 0;
            end
            if (breq) begin
                req_cnt++;
                seen_addr  = baddr;
                seen_be    = bbe;
                seen_wdata = bwdata;
                seen_we    = bwe;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        e_stall = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_berr = 1'b0; e_req = 1'b0;
    endtask

    task automatic drop_inputs();
        mem_read = 1'b0; mem_write = 1'b0; gnt = 1'b0; rvalid = 1'b0; berr_in = 1'b0;
    endtask

    // One core request; gd/rdly = cycles before gnt/rvalid (>= TIMEOUT means never)
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int gd,
                           input int rdly, input bit err, input logic [31:0] rdat);
        logic [1:0] f;
        bit fail;
        mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
        gnt = 1'b0; rvalid = 1'b0; berr_in = 1'b0;
        f = m_fault(rd, wr, f3, a);
        idle_exp();
        if (f != 2'b00) begin
            e_done = 1'b1; e_mis = f[0]; e_berr = f[1];
            step();
            drop_inputs();
            idle_exp();
            return;
        end
        e_stall = 1'b1;
        e_addr  = {a[31:2], 2'b00};
        e_we    = wr;
        e_be    = m_be(f3, a);
        e_wdata = m_wdata(f3, wd);
        step();
        e_req = 1'b1;
        for (int j = 0; j < int'(TIMEOUT); j++) begin
            gnt     = (j == gd);
            berr_in = (j == gd && wr) ? err : 1'($urandom % 2);
            brdata  = $urandom;
            step();
            gnt = 1'b0;
            if (j == gd) break;
        end
        fail  = (gd >= int'(TIMEOUT)) || (wr && err);
        e_req = 1'b0;
        if (rd && gd < int'(TIMEOUT)) begin
            for (int j = 0; j < int'(TIMEOUT); j++) begin
                rvalid  = (j == rdly);
                berr_in = (j == rdly) ? err : 1'($urandom % 2);
                brdata  = (j == rdly) ? rdat : $urandom;
                step();
                rvalid = 1'b0;
                if (j == rdly) break;
            end
            fail = (rdly >= int'(TIMEOUT)) || err;
            if (!fail) model_rdata = m_load(f3, a, rdat);
        end
        berr_in = 1'b0;
        e_stall = 1'b0; e_done = 1'b1; e_berr = fail; e_mis = 1'b0;
        step();
        drop_inputs();
        idle_exp();
    endtask

    initial begin
        int r0;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic rrd, rwr;
        int sel, gd, rd_dly;

        rst_n = 1'b0; chk_en = 1'b0; model_rdata = '0;
        drop_inputs(); func3 = '0; addr = '0; wdata = '0; brdata = '0;
        lat_run = 0; last_lat = 0; req_cnt = 0;
        seen_addr = '0; seen_wdata = '0; seen_be = '0; seen_we = 1'b0;
        idle_exp(); e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst stall", 32'(stall), 32'd0);
        cmp("rst done", 32'(done), 32'd0);
        cmp("rst bus_req", 32'(breq), 32'd0);
        cmp("rst rdata", rdata, 32'd0);
        cmp("rst bus_addr", baddr, 32'd0);
        cmp("rst bus_be", 32'(bbe), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // lb with sign extension, 4-cycle load latency
        run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 1'b0, 32'h8011_2233);
        cmp("t1 addr", seen_addr, 32'h100);
        cmp("t1 be", 32'(seen_be), 32'h8);
        cmp("t1 rdata", rdata, 32'hFFFF_FF80);
        cmp("t1 latency", 32'(last_lat), 32'd4);
        step();
        // lhu / lh upper half
        run_txn(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 1, 2, 1'b0, 32'hBEEF_1234);
        cmp("t2 lhu", rdata, 32'h0000_BEEF);
        run_txn(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 0, 1'b0, 32'hBEEF_1234);
        cmp("t2 lh", rdata, 32'hFFFF_BEEF);
        // sh with grant in the third request cycle
        r0 = req_cnt;
        run_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_CAFE, 2, 0, 1'b0, 32'h0);
        cmp("t3 be", 32'(seen_be), 32'hC);
        cmp("t3 wdata", seen_wdata, 32'hCAFE_CAFE);
        cmp("t3 we", 32'(seen_we), 32'd1);
        cmp("t3 req cycles", 32'(req_cnt - r0), 32'd3);
        cmp("t3 latency", 32'(last_lat), 32'd5);
        // misaligned lw and illegal store size: no bus access
        r0 = req_cnt;
        run_txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 1'b0, 32'h0);
        cmp("t4 lw latency", 32'(last_lat), 32'd1);
        run_txn(1'b0, 1'b1, 3'b011, 32'h100, 32'h1234, 0, 0, 1'b0, 32'h0);
        cmp("t4 no req", 32'(req_cnt - r0), 32'd0);
        step();
        // grant never arrives
        r0 = req_cnt;
        run_txn(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1000, 0, 1'b0, 32'h0);
        cmp("t5 req cycles", 32'(req_cnt - r0), 32'(TIMEOUT));
        cmp("t5 rdata kept", rdata, 32'hFFFF_BEEF);
        step();

        // reset while waiting for read data
        chk_en = 1'b0;
        mem_read = 1'b1; func3 = 3'b010; addr = 32'h300;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        #2;
        rst_n = 1'b0; mem_read = 1'b0;
        #1;
        cmp("t6 bus_req", 32'(breq), 32'd0);
        cmp("t6 stall", 32'(stall), 32'd0);
        cmp("t6 rdata", rdata, 32'd0);
        model_rdata = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1; idle_exp();
        rvalid = 1'b1; brdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        step();
        run_txn(1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_005A, 0, 0, 1'b0, 32'h0);
        cmp("t6 sb be", 32'(seen_be), 32'h2);
        cmp("t6 sb wdata", seen_wdata, 32'h5A5A_5A5A);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            sel = int'($urandom % 20);
            rrd = (sel < 10) || (sel == 19);
            rwr = (sel >= 10);
            rf3 = 3'($urandom);
            ra  = $urandom;
            if ($urandom % 4 != 0) ra = ra & ~((32'd1 << rf3[1:0]) - 32'd1);
            gd     = ($urandom % 16 == 0) ? int'(TIMEOUT) + 5 : int'($urandom % 4);
            rd_dly = ($urandom % 16 == 0) ? int'(TIMEOUT) + 5 : int'($urandom % 4);
            run_txn(rrd, rwr, rf3, ra, $urandom, gd, rd_dly, ($urandom % 8 == 0), $urandom);
            repeat ($urandom % 3) step();
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
